ring_rd_ctrl: RTL
=================

# ring_rd_ctrl

Read-side controller for a circular buffer whose write side is advanced by a wrap-around write counter. It tracks occupancy from the writer's increment pulse and owns the wrapping read pointer. It issues reads to a 1-cycle-latency memory and presents the returned data on a valid/ready output through a 2-entry skid buffer. It sits between the buffer memory and the downstream consumer, and returns `o__full` to the writer.

## Interface
- `NUM_ENTRIES`, 8: buffer depth; any value ≥ 2, power of two not required.
- `PTR_WIDTH`, `$clog2(NUM_ENTRIES)`: read-address width.
- `CNT_WIDTH`, `$clog2(NUM_ENTRIES+1)`: occupancy width.
- `DATA_WIDTH`, 32: entry width.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-low. Asserted when 0, sampled on posedge `clk`.
- `i__wr_en`  in  1: writer committed one entry this cycle. This is the same pulse that increments the write counter.
- `o__full`  out  1: `mem_cnt == NUM_ENTRIES`. The writer must not assert `i__wr_en` while it is high.
- `o__overflow`  out  1: sticky flag for a protocol violation.
- `o__count`  out  CNT_WIDTH: `mem_cnt`, the number of entries written but not yet read.
- `o__rd_en`  out  1: memory read strobe (combinational).
- `o__rd_addr`  out  PTR_WIDTH: read pointer (registered).
- `i__rd_data`  in  DATA_WIDTH: memory data, valid the cycle after `o__rd_en`.
- `o__valid`  out  1: head of the skid buffer is valid.
- `o__data`  out  DATA_WIDTH: head entry.
- `i__ready`  in  1: consumer accepts; a pop occurs when `o__valid & i__ready`.

## Operation
- State:
  - `rd_ptr`, PTR_WIDTH.
  - `mem_cnt`, CNT_WIDTH.
  - `inflight`, 1 bit: the registered `o__rd_en`.
  - skid buffer of 2 × DATA_WIDTH, with `buf_cnt` in the range 0..2.
  - `overflow`.
- Issue rule: `o__rd_en = (mem_cnt != 0) && (buf_cnt + inflight - pop < 2)`.
  - This reserves buffer space for every in-flight read, so returned data is never dropped.
- `rd_ptr` advances on `o__rd_en`.
  - Wraps from `NUM_ENTRIES-1` to 0.
  - Otherwise increments by 1.
- Occupancy update: `mem_cnt_next = mem_cnt + i__wr_en - o__rd_en`.
  - If `i__wr_en` and `o__rd_en` occur in the same cycle, the count is unchanged.
  - A slot is freed at read issue, not at pop.
- Illegal write: `i__wr_en` while `o__full`.
  - `mem_cnt` saturates at `NUM_ENTRIES`.
  - `overflow` sets and holds until reset.
  - `rd_ptr` is not disturbed.
- Data return: when `inflight` is 1, `i__rd_data` is written into the skid buffer.
  - It goes to the head if the buffer is empty, or if the buffer holds one entry and that entry pops this cycle.
  - Otherwise it goes to the second slot.
- Pop: the head is removed and the second slot shifts into the head. A push and a pop in the same cycle are both legal.
- Ordering is strict FIFO; entries leave in `rd_ptr` order.

## Timing
- Reset values:
  - `rd_ptr` = 0, `mem_cnt` = 0, `inflight` = 0, `buf_cnt` = 0.
  - Outputs: `o__valid` = 0, `o__full` = 0, `o__overflow` = 0, `o__rd_en` = 0.
  - `o__data` is don't-care.
- Reset mid-operation: a read in flight at reset is discarded, and `i__rd_data` in the following cycle is ignored.
- Latency from `i__wr_en` in cycle t, with the buffer empty and idle:
  - `mem_cnt` = 1 at t+1.
  - `o__rd_en` at t+1.
  - Data on `i__rd_data` at t+2.
  - `o__valid` = 1 at t+3.
- Throughput: one pop per cycle is sustained with `i__ready` held at 1.
- Stall: with `i__ready` = 0, at most 2 entries are buffered, then `o__rd_en` deasserts.
  - When `i__ready` returns to 1, there is no bubble: the second entry is already held.
- `o__full`, `o__count` and `o__overflow` are registered-state functions with no combinational path from inputs.
- `o__rd_en` depends combinationally on `i__ready`.

## Structure
- No shared package is required. Width parameters are derived locally.
- If a memory interface typedef is later shared, it belongs in the buffer's common package.
- Natural sub-module: `counter` (the team's wrap-around incrementer) for `rd_ptr`.
  - `NUM_COUNT = NUM_ENTRIES`.
  - `i__inc = o__rd_en`.
  - Its reset is driven by `~reset`.
- The skid buffer is inline logic (2 entries).

## Test plan
- Single entry: reset, then one `i__wr_en` at cycle 5.
  - Expect `o__rd_en` at 6, `o__rd_addr` = 0, `o__valid` at 8.
  - After the pop: `o__count` = 0, `o__valid` = 0.
- Fill and full: `NUM_ENTRIES` = 8, 8 back-to-back writes, `i__ready` = 0.
  - 2 reads issue, and `o__count` settles at 6.
  - 2 more writes raise `o__count` to 8 and `o__full` to 1.
  - A 9th write sets `o__overflow`, and `o__count` stays at 8.
- Wrap-around: `NUM_ENTRIES` = 5, 12 writes and pops with `i__ready` = 1.
  - `o__rd_addr` sequence: 0,1,2,3,4,0,1,…
  - Data order matches the memory model.
- Backpressure: stream with `i__ready` toggling 1,0,0,1.
  - No data is lost or duplicated.
  - `buf_cnt` never exceeds 2.
  - No bubble on resume.
- Simultaneous write and read issue while `mem_cnt` = 3: `o__count` stays at 3.
- Reset mid-operation: assert `reset` = 0 in the cycle a read is issued.
  - The next cycle's `i__rd_data` is ignored.
  - All outputs take their reset values.

Source files
------------

// File: rtl/ring_rd_ctrl_pkg.sv
// Shared types and helpers for the ring buffer read-side controller.
// Contents:
//   SKID_DEPTH    - number of entries held by the output skid buffer
//   skid_cnt_t    - occupancy type for the skid buffer (0..SKID_DEPTH)
//   skid_has_room - issue gate: true when a new read still has a reserved slot
package ring_rd_ctrl_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  // Occupancy after this cycle counts reads still in flight, so a returning
  // word always has a slot waiting for it.
  function automatic logic skid_has_room(input skid_cnt_t cnt, input logic inflight,
                                         input logic pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return occ < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/ring_rd_ctrl_counter.sv
// Wrap-around incrementer: counts 0..NUM_COUNT-1 and wraps back to 0.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (clears the count)
//   i__inc   - advance by one this cycle
//   o__count - current count
module ring_rd_ctrl_counter #(
  parameter int unsigned NUM_COUNT = 8,
  parameter int unsigned WIDTH     = $clog2(NUM_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i__inc,
  output logic [WIDTH-1:0] o__count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i__inc) begin
      count_d = (count_q == WIDTH'(NUM_COUNT - 1)) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o__count = count_q;

endmodule

// File: rtl/ring_rd_ctrl.sv
// Read-side controller for a circular buffer. Tracks occupancy from the
// writer's commit pulse, owns the wrapping read pointer, issues reads to a
// 1-cycle-latency memory and presents returned words through a 2-entry skid
// buffer on a valid/ready output.
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   i__wr_en      - writer committed one entry
//   o__full       - occupancy equals NUM_ENTRIES
//   o__overflow   - sticky: write seen while full
//   o__count      - entries written but not yet read
//   o__rd_en      - memory read strobe (combinational)
//   o__rd_addr    - read pointer
//   i__rd_data    - memory data, valid the cycle after o__rd_en
//   o__valid/o__data/i__ready - downstream valid/ready head entry
module ring_rd_ctrl
  import ring_rd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PTR_WIDTH   = $clog2(NUM_ENTRIES),
  parameter int unsigned CNT_WIDTH   = $clog2(NUM_ENTRIES + 1),
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__wr_en,
  output logic                  o__full,
  output logic                  o__overflow,
  output logic [CNT_WIDTH-1:0]  o__count,
  output logic                  o__rd_en,
  output logic [PTR_WIDTH-1:0]  o__rd_addr,
  input  logic [DATA_WIDTH-1:0] i__rd_data,
  output logic                  o__valid,
  output logic [DATA_WIDTH-1:0] o__data,
  input  logic                  i__ready
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  logic [CNT_WIDTH-1:0]  mem_cnt_q, mem_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  inflight_q, inflight_d;
  skid_cnt_t             skid_cnt_q, skid_cnt_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;

  logic                  pop;
  logic                  rd_en;
  logic [CW1-1:0]        cnt_sum;
  skid_cnt_t             slot;

  assign o__valid    = (skid_cnt_q != '0);
  assign o__data     = skid0_q;
  assign o__full     = (mem_cnt_q == CNT_WIDTH'(NUM_ENTRIES));
  assign o__overflow = overflow_q;
  assign o__count    = mem_cnt_q;
  assign o__rd_en    = rd_en;

  assign pop   = o__valid & i__ready;
  assign rd_en = (mem_cnt_q != '0) && skid_has_room(skid_cnt_q, inflight_q, pop);

  always_comb begin
    // A slot is released at read issue; an illegal write saturates the count.
    cnt_sum    = {1'b0, mem_cnt_q} + CW1'(i__wr_en) - CW1'(rd_en);
    mem_cnt_d  = (cnt_sum > CW1'(NUM_ENTRIES)) ? CNT_WIDTH'(NUM_ENTRIES)
                                                : cnt_sum[CNT_WIDTH-1:0];
    overflow_d = overflow_q | (i__wr_en & o__full);
    inflight_d = rd_en;
  end

  always_comb begin
    skid0_d = skid0_q;
    skid1_d = skid1_q;
    // Slot the returning word lands in, after any pop this cycle.
    slot    = skid_cnt_q - skid_cnt_t'(pop);
    if (pop) begin
      skid0_d = skid1_q;
    end
    if (inflight_q) begin
      if (slot == '0) begin
        skid0_d = i__rd_data;
      end else begin
        skid1_d = i__rd_data;
      end
    end
    skid_cnt_d = slot + skid_cnt_t'(inflight_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_cnt_q  <= '0;
      overflow_q <= 1'b0;
      inflight_q <= 1'b0;
      skid_cnt_q <= '0;
    end else begin
      mem_cnt_q  <= mem_cnt_d;
      overflow_q <= overflow_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Skid payload needs no reset; skid_cnt_q qualifies it.
  always_ff @(posedge clk) begin
    skid0_q <= skid0_d;
    skid1_q <= skid1_d;
  end

  ring_rd_ctrl_counter #(
    .NUM_COUNT (NUM_ENTRIES),
    .WIDTH     (PTR_WIDTH)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (~reset),
    .i__inc   (rd_en),
    .o__count (o__rd_addr)
  );

endmodule
